fsm_bit_serializer: RTL and testbench
=====================================

// Module: fsm_bit_serializer
// PURPOSE
//   Upstream feeder for the 10110 sequence-detector FSM. Accepts WIDTH-bit
//   parallel words over a valid/ready handshake and drives them out one bit
//   per enabled clock on data_out, which connects straight to the detector's
//   data_in. A one-word holding register lets consecutive words stream with
//   no idle bit between them.
// PARAMETERS
//   WIDTH      8   bits per word; legal range is WIDTH >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//   IDLE_BIT   0   level driven on data_out when no word is being sent
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_data    in   WIDTH  parallel word
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      hold register can take a word (= !hold_full && !rst)
//   en         in   1      bit-advance enable; 0 stalls the current bit
//   data_out   out  1      serial bit (registered), goes to detector data_in
//   bit_valid  out  1      data_out carries a real word bit (registered)
//   word_start out  1      data_out carries the first bit of a word (registered)
//   busy       out  1      state==SHIFT or hold_full
// BEHAVIOUR
//   Internal state: sh[WIDTH], cnt (counts 0..WIDTH-1), hold[WIDTH],
//   hold_full, and the FSM state (IDLE or SHIFT).
//   Reset: when rst is sampled high at a clock edge, the block sets
//     state=IDLE, cnt=0, sh=0, hold_full=0, data_out=IDLE_BIT, bit_valid=0
//     and word_start=0. in_ready is 0 while rst is high. Any word in flight
//     and any held word are discarded. After rst drops, in_ready=1.
//   Accept: a word is accepted at an edge where in_valid && in_ready. On that
//     edge hold<=in_data and hold_full<=1. The block never accepts while
//     hold_full=1.
//   Load condition: load = hold_full && (state==IDLE ||
//     (state==SHIFT && en && cnt==WIDTH-1)). A load sets sh<=hold, cnt<=0,
//     state<=SHIFT, hold_full<=0 and word_start<=1. An IDLE load is NOT gated
//     by en. Accept and load never hit the same edge, because accept requires
//     hold_full=0 and load requires hold_full=1.
//   SHIFT with en=1 and cnt<WIDTH-1: shift sh toward the output end
//     (MSB_FIRST: left; otherwise right), cnt<=cnt+1, word_start<=0.
//   SHIFT with en=1, cnt==WIDTH-1 and no load: state<=IDLE, bit_valid<=0,
//     data_out<=IDLE_BIT, word_start<=0.
//   SHIFT with en=0: sh, cnt, data_out, bit_valid and word_start all hold.
//     Each bit is therefore presented for one cycle per en pulse.
//   data_out is registered as the output-end bit of the next sh
//     (MSB_FIRST ? sh[WIDTH-1] : sh[0]). bit_valid=1 in every SHIFT cycle.
//   Latency: with accept at edge E0 into an IDLE block, the load happens at
//     E0+1 and the first bit is on data_out in the cycle after E0+1.
//   Throughput: with en held at 1 and the next word accepted at least one
//     cycle before the last bit, words go out back-to-back with no gap.
//   Wrap: cnt never exceeds WIDTH-1. It returns to 0 only on a load.
// TESTING
//   T1 MSB_FIRST=1, en=1, send 8'hB0 -> data_out=1,0,1,1,0,0,0,0 starting
//      2 clocks after accept; word_start high on the first bit only;
//      bit_valid high for exactly 8 cycles, then data_out=0.
//   T2 Send 8'hB0 then 8'h5A with in_valid held high -> 16 consecutive
//      bit_valid cycles with no gap; word_start on bits 0 and 8; in_ready
//      low while hold_full=1.
//   T3 Hold en=0 for 3 cycles at bit index 3 of 8'hB0 -> data_out holds 1
//      for those 3 cycles; the sequence then resumes 0,0,0,0; 11 bit_valid
//      cycles in total.
//   T4 MSB_FIRST=0, send 8'h0D -> data_out=1,0,1,1,0,0,0,0.
//   T5 Assert rst during bit 4, with a second word held -> next cycle
//      bit_valid=0 and data_out=0; in_ready=0 while rst is high; after
//      release in_ready=1 and busy=0; the held word is never emitted.
//   T6 End-to-end with the 10110 detector: stream 8'hB0 -> the detector
//      reaches its final state exactly once, on the 5th bit.

Source files
------------

// File: rtl/fsm_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fsm_bit_serializer
// Purpose  : Parallel-to-serial feeder for the 10110 sequence detector.
//            Takes WIDTH-bit words over a valid/ready handshake and emits them
//            one bit per enabled clock. A one-word hold register lets words
//            stream back-to-back with no idle bit between them.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous reset, active-high
//            in_data    - parallel input word (WIDTH bits)
//            in_valid   - in_data is valid
//            in_ready   - hold register can take a word
//            en         - bit-advance enable; 0 stalls the current bit
//            data_out   - registered serial bit (to detector data_in)
//            bit_valid  - data_out carries a real word bit
//            word_start - data_out carries the first bit of a word
//            busy       - shifting a word or holding one
// Revision : 1.0 - initial release
// ============================================================================
module fsm_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic             data_out,
    output logic             bit_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    // State registers
    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic               r_data_out;
    logic               r_bit_valid;
    logic               r_word_start;

    // Next-state values
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic [WIDTH-1:0]   w_hold_nxt;
    logic               w_hold_full_nxt;
    logic               w_data_out_nxt;
    logic               w_bit_valid_nxt;
    logic               w_word_start_nxt;

    // Datapath helpers
    logic [WIDTH-1:0]   w_sh_shifted;   // sh moved one place toward the output end
    logic               w_shift_head;   // output-end bit of w_sh_shifted
    logic               w_hold_head;    // output-end bit of the held word
    logic               w_shift_step;
    logic               w_at_last;
    logic               w_load;
    logic               w_accept;

    // Bit-order selection. The bit that falls off the output end has already
    // been presented on data_out, so it is never read again.
    generate
        if (MSB_FIRST) begin : g_msb_first
            logic w_unused_end;
            assign w_unused_end = r_sh[WIDTH-1];
            assign w_sh_shifted = {r_sh[WIDTH-2:0], 1'b0};
            assign w_shift_head = r_sh[WIDTH-2];
            assign w_hold_head  = r_hold[WIDTH-1];
        end else begin : g_lsb_first
            logic w_unused_end;
            assign w_unused_end = r_sh[0];
            assign w_sh_shifted = {1'b0, r_sh[WIDTH-1:1]};
            assign w_shift_head = r_sh[1];
            assign w_hold_head  = r_hold[0];
        end
    endgenerate

    assign in_ready     = !r_hold_full && !rst;
    assign w_accept     = in_valid && in_ready;
    assign w_shift_step = (r_state == c_ST_SHIFT) && en;
    assign w_at_last    = (r_cnt == c_LAST);
    // An IDLE load ignores en so a fresh word starts as soon as it is held;
    // a SHIFT load chains onto the last enabled bit for gapless streaming.
    assign w_load       = r_hold_full &&
                          ((r_state == c_ST_IDLE) || (w_shift_step && w_at_last));

    // Next-state and output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sh_nxt         = r_sh;
        w_hold_nxt       = r_hold;
        w_hold_full_nxt  = r_hold_full;
        w_data_out_nxt   = r_data_out;
        w_bit_valid_nxt  = r_bit_valid;
        w_word_start_nxt = r_word_start;

        // Accept needs hold_full=0 and load needs hold_full=1, so the two
        // updates of hold_full below never collide.
        if (w_accept) begin
            w_hold_nxt      = in_data;
            w_hold_full_nxt = 1'b1;
        end

        if (w_load) begin
            w_sh_nxt         = r_hold;
            w_cnt_nxt        = '0;
            w_state_nxt      = c_ST_SHIFT;
            w_hold_full_nxt  = 1'b0;
            w_word_start_nxt = 1'b1;
            w_bit_valid_nxt  = 1'b1;
            w_data_out_nxt   = w_hold_head;
        end else if (w_shift_step && !w_at_last) begin
            w_sh_nxt         = w_sh_shifted;
            w_cnt_nxt        = r_cnt + c_CNT_W'(1);
            w_word_start_nxt = 1'b0;
            w_bit_valid_nxt  = 1'b1;
            w_data_out_nxt   = w_shift_head;
        end else if (w_shift_step && w_at_last) begin
            w_state_nxt      = c_ST_IDLE;
            w_bit_valid_nxt  = 1'b0;
            w_data_out_nxt   = IDLE_BIT;
            w_word_start_nxt = 1'b0;
        end
        // SHIFT with en=0 falls through: everything holds.
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_sh         <= '0;
            r_hold_full  <= 1'b0;
            r_data_out   <= IDLE_BIT;
            r_bit_valid  <= 1'b0;
            r_word_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sh         <= w_sh_nxt;
            r_hold_full  <= w_hold_full_nxt;
            r_data_out   <= w_data_out_nxt;
            r_bit_valid  <= w_bit_valid_nxt;
            r_word_start <= w_word_start_nxt;
        end
    end

    // Hold data is qualified by r_hold_full, so it needs no reset.
    always_ff @(posedge clk) begin
        r_hold <= w_hold_nxt;
    end

    assign data_out   = r_data_out;
    assign bit_valid  = r_bit_valid;
    assign word_start = r_word_start;
    assign busy       = (r_state == c_ST_SHIFT) || r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_fsm_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_bit_serializer
// Purpose  : Directed self-checking bench for fsm_bit_serializer. One
//            MSB-first and one LSB-first instance share clock, reset and en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in_data,  in_data1;
    logic       in_valid, in_valid1;
    logic       in_ready, in_ready1;
    logic       data_out, data_out1;
    logic       bit_valid, bit_valid1;
    logic       word_start, word_start1;
    logic       busy, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .en         (en),
        .data_out   (data_out),
        .bit_valid  (bit_valid),
        .word_start (word_start),
        .busy       (busy)
    );

    fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .en         (en),
        .data_out   (data_out1),
        .bit_valid  (bit_valid1),
        .word_start (word_start1),
        .busy       (busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference 10110 overlapping detector, Moore style, state 5 = found.
    function automatic int det_next(input int s, input logic b);
        case (s)
            0: return b ? 1 : 0;
            1: return b ? 1 : 2;
            2: return b ? 3 : 0;
            3: return b ? 4 : 2;
            4: return b ? 1 : 5;
            5: return b ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    initial begin
        logic [7:0]  seq8;
        logic [15:0] seq16;
        logic [10:0] seq11;
        int          cnt;
        int          det_s;
        int          hits;
        int          hit_at;

        rst = 1'b1; en = 1'b1;
        in_data = '0; in_valid = 1'b0;
        in_data1 = '0; in_valid1 = 1'b0;
        tick(); tick();

        // Reset state
        check_eq("rst_in_ready",   in_ready,   0);
        check_eq("rst_bit_valid",  bit_valid,  0);
        check_eq("rst_data_out",   data_out,   0);
        check_eq("rst_word_start", word_start, 0);
        check_eq("rst_busy",       busy,       0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);

        // T1: single word 8'hB0, MSB first
        seq8 = 8'b1011_0000;
        in_data = 8'hB0; in_valid = 1'b1;
        tick();                       // accept edge
        in_valid = 1'b0;
        check_eq("t1_busy_after_accept", busy, 1);
        check_eq("t1_in_ready_held",     in_ready, 0);
        check_eq("t1_no_bit_yet",        bit_valid, 0);
        tick();                       // load edge
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t1_bit%0d", i),   data_out,   seq8[7-i]);
            check_eq($sformatf("t1_valid%0d", i), bit_valid,  1);
            check_eq($sformatf("t1_ws%0d", i),    word_start, (i == 0));
            tick();
        end
        check_eq("t1_end_valid", bit_valid, 0);
        check_eq("t1_end_data",  data_out,  0);
        check_eq("t1_end_busy",  busy,      0);

        // T2: 8'hB0 then 8'h5A back-to-back
        seq16 = 16'b1011_0000_0101_1010;
        in_data = 8'hB0; in_valid = 1'b1;
        tick();                       // accept B0
        in_data = 8'h5A;
        tick();                       // load B0
        for (int i = 0; i < 16; i++) begin
            if (i == 0) check_eq("t2_ready_bit0", in_ready, 1);
            if (i == 1) begin
                check_eq("t2_ready_held", in_ready, 0);
                in_valid = 1'b0;
            end
            if (i == 8) check_eq("t2_ready_after_load", in_ready, 1);
            check_eq($sformatf("t2_bit%0d", i),   data_out,   seq16[15-i]);
            check_eq($sformatf("t2_valid%0d", i), bit_valid,  1);
            check_eq($sformatf("t2_ws%0d", i),    word_start, (i == 0 || i == 8));
            tick();
        end
        check_eq("t2_end_valid", bit_valid, 0);

        // T3: en low for 3 cycles while bit 3 of 8'hB0 is shown
        seq11 = 11'b101_1111_0000;
        in_data = 8'hB0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        cnt = 0;
        for (int j = 0; j < 11; j++) begin
            check_eq($sformatf("t3_bit%0d", j), data_out, seq11[10-j]);
            if (bit_valid) cnt++;
            en = (j >= 3 && j <= 5) ? 1'b0 : 1'b1;
            tick();
        end
        en = 1'b1;
        check_eq("t3_valid_cycles", cnt, 11);
        check_eq("t3_end_valid", bit_valid, 0);

        // T4: LSB-first instance, 8'h0D -> 1,0,1,1,0,0,0,0
        seq8 = 8'b1011_0000;
        in_data1 = 8'h0D; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t4_bit%0d", i), data_out1,  seq8[7-i]);
            check_eq($sformatf("t4_ws%0d", i),  word_start1, (i == 0));
            tick();
        end
        check_eq("t4_end_valid", bit_valid1, 0);

        // T5: reset during bit 4 with a second word held
        in_data = 8'hB0; in_valid = 1'b1;
        tick();
        in_data = 8'hFF;
        tick();                       // bit 0 of B0 shown
        tick();                       // FF accepted into hold, bit 1
        in_valid = 1'b0;
        check_eq("t5_held", in_ready, 0);
        tick(); tick(); tick();       // bit 4 shown
        check_eq("t5_bit4_valid", bit_valid, 1);
        rst = 1'b1;
        #1;
        check_eq("t5_ready_in_rst", in_ready, 0);
        tick();
        check_eq("t5_rst_valid",      bit_valid,  0);
        check_eq("t5_rst_data",       data_out,   0);
        check_eq("t5_rst_ws",         word_start, 0);
        check_eq("t5_ready_still_rst", in_ready,  0);
        rst = 1'b0;
        #1;
        check_eq("t5_ready_after", in_ready, 1);
        check_eq("t5_busy_after",  busy,     0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bit_valid) cnt++;
        end
        check_eq("t5_no_held_emit", cnt, 0);

        // T6: stream 8'hB0 into the reference 10110 detector
        det_s = 0; hits = 0; hit_at = 0; cnt = 0;
        in_data = 8'hB0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bit_valid) begin
                cnt++;
                det_s = det_next(det_s, data_out);
                if (det_s == 5) begin
                    hits++;
                    hit_at = cnt;
                end
            end
        end
        check_eq("t6_bits",   cnt,    8);
        check_eq("t6_hits",   hits,   1);
        check_eq("t6_hit_at", hit_at, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
